// File: rtl/obj_pos_ctrl.sv
// Frame-rate position controller for one on-screen rectangle: button-driven
// clamped motion per frame tick, per-frame hit latch and multi-frame freeze penalty.
module obj_pos_ctrl #(
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int OBJ_W         = 32,
   parameter int OBJ_H         = 32,
   parameter int INIT_X        = 304,
   parameter int INIT_Y        = 224,
   parameter int STEP          = 4,
   parameter int FREEZE_FRAMES = 30
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Frame_Tick,
   input  logic        i_Btn_Left,
   input  logic        i_Btn_Right,
   input  logic        i_Btn_Up,
   input  logic        i_Btn_Down,
   input  logic        i_fHit,
   input  logic        i_Restart,
   output logic [18:0] o_Obj_Pos,
   output logic [5:0]  o_Obj_W,
   output logic [5:0]  o_Obj_H,
   output logic        o_fFrozen,
   output logic [7:0]  o_Hit_Cnt
);

   localparam logic [10:0] MAX_X   = 11'(SCREEN_W - OBJ_W);
   localparam logic [10:0] MAX_Y   = 11'(SCREEN_H - OBJ_H);
   localparam logic [10:0] STEP_W  = 11'(STEP);
   localparam logic [9:0]  INIT_XW = 10'(INIT_X);
   localparam logic [8:0]  INIT_YW = 9'(INIT_Y);
   localparam logic [7:0]  FRZ_W   = 8'(FREEZE_FRAMES);

   typedef enum logic {RUN, FROZEN} state_t;

   state_t     state;
   logic [9:0] x;
   logic [8:0] y;
   logic [7:0] freeze_cnt;
   logic [7:0] hit_cnt;
   logic       hit_pending;
   logic       frozen;

   // One axis of motion; 11-bit math so neither edge can wrap.
   function automatic logic [10:0] step_axis(input logic [10:0] p, input logic dec,
                                             input logic inc, input logic [10:0] max);
      if (inc && !dec)
         return (p + STEP_W > max) ? max : p + STEP_W;
      if (dec && !inc)
         return (p < STEP_W) ? 11'd0 : p - STEP_W;
      return p;
   endfunction

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state       <= RUN;
         x           <= INIT_XW;
         y           <= INIT_YW;
         freeze_cnt  <= '0;
         hit_cnt     <= '0;
         hit_pending <= 1'b0;
         frozen      <= 1'b0;
      end else if (i_Restart) begin
         state       <= RUN;
         x           <= INIT_XW;
         y           <= INIT_YW;
         freeze_cnt  <= '0;
         hit_cnt     <= '0;
         hit_pending <= 1'b0;
         frozen      <= 1'b0;
      end else begin
         // A hit in the tick cycle itself belongs to the frame that is starting.
         hit_pending <= i_Frame_Tick ? i_fHit : (hit_pending | i_fHit);
         if (i_Frame_Tick) begin
            case (state)
               RUN: begin
                  if (hit_pending) begin
                     state      <= FROZEN;
                     frozen     <= 1'b1;
                     freeze_cnt <= FRZ_W;
                     if (hit_cnt != 8'hFF)
                        hit_cnt <= hit_cnt + 8'd1;
                  end else begin
                     x <= 10'(step_axis({1'b0, x}, i_Btn_Left, i_Btn_Right, MAX_X));
                     y <= 9'(step_axis({2'b0, y}, i_Btn_Up, i_Btn_Down, MAX_Y));
                  end
               end
               FROZEN: begin
                  if (freeze_cnt <= 8'd1) begin
                     state      <= RUN;
                     frozen     <= 1'b0;
                     freeze_cnt <= '0;
                  end else begin
                     freeze_cnt <= freeze_cnt - 8'd1;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

   assign o_Obj_Pos = {x, y};
   assign o_Obj_W   = 6'(OBJ_W);
   assign o_Obj_H   = 6'(OBJ_H);
   assign o_fFrozen = frozen;
   assign o_Hit_Cnt = hit_cnt;

endmodule

// File: tb/tb_obj_pos_ctrl.sv
// Bench for obj_pos_ctrl: directed table plus corner sequences on two parameter
// sets, then random traffic against a frame-level reference model.
module tb_obj_pos_ctrl;

   localparam int STEP = 4;

   typedef struct packed {
      logic rst, tick, hit, l, r, u, d;
   } in_t;

   typedef struct {
      int x, y, left, hits;
      bit pend;
      int ix, iy, ff, maxx, maxy;
   } mdl_t;

   typedef struct {
      in_t i;
      int  ex, ey, efz, eh;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   in_t  ia, ib;
   logic [18:0] pos_a, pos_b;
   logic [5:0]  wa, ha, wb, hb;
   logic        fz_a, fz_b;
   logic [7:0]  hc_a, hc_b;
   mdl_t ma, mb;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   obj_pos_ctrl dut_a (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Frame_Tick(ia.tick),
      .i_Btn_Left(ia.l), .i_Btn_Right(ia.r), .i_Btn_Up(ia.u), .i_Btn_Down(ia.d),
      .i_fHit(ia.hit), .i_Restart(ia.rst),
      .o_Obj_Pos(pos_a), .o_Obj_W(wa), .o_Obj_H(ha), .o_fFrozen(fz_a), .o_Hit_Cnt(hc_a)
   );

   obj_pos_ctrl #(.INIT_X(2), .INIT_Y(446), .FREEZE_FRAMES(1)) dut_b (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Frame_Tick(ib.tick),
      .i_Btn_Left(ib.l), .i_Btn_Right(ib.r), .i_Btn_Up(ib.u), .i_Btn_Down(ib.d),
      .i_fHit(ib.hit), .i_Restart(ib.rst),
      .o_Obj_Pos(pos_b), .o_Obj_W(wb), .o_Obj_H(hb), .o_fFrozen(fz_b), .o_Hit_Cnt(hc_b)
   );

   function automatic mdl_t mreset(input int ix, input int iy, input int ff);
      mdl_t m;
      m.ix = ix; m.iy = iy; m.ff = ff;
      m.maxx = 640 - 32; m.maxy = 480 - 32;
      m.x = ix; m.y = iy; m.left = 0; m.hits = 0; m.pend = 0;
      return m;
   endfunction

   // Frame-level reference: "left" is the number of frozen ticks still owed.
   function automatic mdl_t mstep(input mdl_t m, input in_t i);
      mdl_t n = m;
      if (i.rst) return mreset(m.ix, m.iy, m.ff);
      if (i.tick) begin
         if (n.left > 0) n.left--;
         else if (n.pend) begin
            n.left = n.ff;
            if (n.hits < 255) n.hits++;
         end else begin
            n.x += (i.r && !i.l) ? STEP : (i.l && !i.r) ? -STEP : 0;
            n.y += (i.d && !i.u) ? STEP : (i.u && !i.d) ? -STEP : 0;
            if (n.x < 0) n.x = 0;
            if (n.x > n.maxx) n.x = n.maxx;
            if (n.y < 0) n.y = 0;
            if (n.y > n.maxy) n.y = n.maxy;
         end
         n.pend = i.hit;
      end else begin
         n.pend = n.pend | i.hit;
      end
      return n;
   endfunction

   function automatic in_t mk(input logic rst, tick, hit, l, r, u, d);
      in_t v;
      v.rst = rst; v.tick = tick; v.hit = hit; v.l = l; v.r = r; v.u = u; v.d = d;
      return v;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic expect_a(input string tag, input int ex, ey, efz, eh);
      chk({tag, ".x"}, int'(pos_a[18:9]), ex);
      chk({tag, ".y"}, int'(pos_a[8:0]), ey);
      chk({tag, ".frozen"}, int'(fz_a), efz);
      chk({tag, ".hits"}, int'(hc_a), eh);
   endtask

   task automatic expect_b(input string tag, input int ex, ey, efz, eh);
      chk({tag, ".x"}, int'(pos_b[18:9]), ex);
      chk({tag, ".y"}, int'(pos_b[8:0]), ey);
      chk({tag, ".frozen"}, int'(fz_b), efz);
      chk({tag, ".hits"}, int'(hc_b), eh);
   endtask

   task automatic cmp_models();
      expect_a("model_a", ma.x, ma.y, (ma.left > 0) ? 1 : 0, ma.hits);
      expect_b("model_b", mb.x, mb.y, (mb.left > 0) ? 1 : 0, mb.hits);
   endtask

   // One clock: drive just after an edge, advance models on the edge, sample 1 later.
   task automatic cyc(input in_t a, input in_t b);
      ia = a; ib = b;
      @(posedge clk);
      ma = mstep(ma, a);
      mb = mstep(mb, b);
      #1 cmp_models();
   endtask

   task automatic async_reset();
      ia = '0; ib = '0;
      #2 rst_n = 1'b0;
      #1 expect_a("async_rst_a", 304, 224, 0, 0);
      expect_b("async_rst_b", 2, 446, 0, 0);
      ma = mreset(304, 224, 30);
      mb = mreset(2, 446, 1);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[11];
      in_t N, T, TR, TLR, TL, HR, H;
      bit prev_a, prev_b;
      in_t ra, rb;

      N   = mk(0, 0, 0, 0, 0, 0, 0);
      T   = mk(0, 1, 0, 0, 0, 0, 0);
      TR  = mk(0, 1, 0, 0, 1, 0, 0);
      TL  = mk(0, 1, 0, 1, 0, 0, 0);
      TLR = mk(0, 1, 0, 1, 1, 0, 0);
      HR  = mk(0, 0, 1, 0, 1, 0, 0);
      H   = mk(0, 0, 1, 0, 0, 0, 0);

      tbl[0]  = '{T,   304, 224, 0, 0};
      tbl[1]  = '{T,   304, 224, 0, 0};
      tbl[2]  = '{T,   304, 224, 0, 0};
      tbl[3]  = '{TR,  308, 224, 0, 0};
      tbl[4]  = '{TR,  312, 224, 0, 0};
      tbl[5]  = '{TR,  316, 224, 0, 0};
      tbl[6]  = '{TLR, 316, 224, 0, 0};
      tbl[7]  = '{TLR, 316, 224, 0, 0};
      tbl[8]  = '{HR,  316, 224, 0, 0};
      tbl[9]  = '{TR,  316, 224, 1, 1};
      tbl[10] = '{HR,  316, 224, 1, 1};

      ia = '0; ib = '0;
      ma = mreset(304, 224, 30);
      mb = mreset(2, 446, 1);
      repeat (3) @(posedge clk);
      #1 expect_a("reset_a", 304, 224, 0, 0);
      expect_b("reset_b", 2, 446, 0, 0);
      chk("obj_w", int'(wa), 32);
      chk("obj_h", int'(ha), 32);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 11; k++) begin
         cyc(tbl[k].i, N);
         expect_a($sformatf("tbl%0d", k), tbl[k].ex, tbl[k].ey, tbl[k].efz, tbl[k].eh);
         cyc(N, N);
      end

      // Freeze window: T1..T30 hold still, hits discarded, T31 moves.
      for (int k = 1; k <= 30; k++) begin
         cyc(TR, N);
         expect_a($sformatf("frz_T%0d", k), 316, 224, (k < 30) ? 1 : 0, 1);
         cyc((k < 30) ? HR : N, N);
      end
      cyc(TR, N);
      expect_a("frz_T31", 320, 224, 0, 1);
      cyc(N, N);

      // Restart beats tick and hit in the same cycle.
      cyc(H, N);
      cyc(T, N);
      expect_a("rs_freeze", 320, 224, 1, 2);
      cyc(N, N);
      for (int k = 1; k <= 9; k++) begin cyc(T, N); cyc(N, N); end
      cyc(mk(1, 1, 1, 0, 1, 0, 0), N);
      expect_a("restart", 304, 224, 0, 0);
      cyc(N, N);
      cyc(TR, N);
      expect_a("rs_move", 308, 224, 0, 0);
      cyc(N, N);

      // Asynchronous reset in the middle of a freeze.
      cyc(H, N);
      cyc(T, N);
      expect_a("ar_freeze", 308, 224, 1, 1);
      cyc(N, N); cyc(T, N); cyc(H, N);
      async_reset();
      cyc(N, N);
      cyc(TR, N);
      expect_a("ar_move", 308, 224, 0, 0);
      cyc(N, N);

      // Clamp edges on the second instance.
      cyc(N, TL);
      expect_b("clamp_left", 0, 446, 0, 0);
      cyc(N, N);
      cyc(N, mk(1, 0, 0, 0, 0, 0, 0));
      expect_b("b_restart", 2, 446, 0, 0);
      cyc(N, N);
      for (int k = 1; k <= 152; k++) begin
         cyc(N, mk(0, 1, 0, 0, 1, 0, 1));
         if (k == 1)   expect_b("clamp_down", 6, 448, 0, 0);
         if (k == 151) expect_b("right_606", 606, 448, 0, 0);
         if (k == 152) expect_b("clamp_right", 608, 448, 0, 0);
         cyc(N, N);
      end

      // Hit counter saturation with one-frame freezes.
      cyc(N, mk(1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 260; k++) begin
         cyc(N, H);
         cyc(N, T);
         if (k == 0)   expect_b("sat_first", 2, 446, 1, 1);
         if (k == 254) expect_b("sat_255", 2, 446, 1, 255);
         cyc(N, N);
         cyc(N, T);
         cyc(N, N);
      end
      expect_b("sat_end", 2, 446, 0, 255);

      // Random traffic against the reference model.
      prev_a = 0; prev_b = 0;
      for (int n = 0; n < 4000; n++) begin
         ra = in_t'(7'($urandom));
         rb = in_t'(7'($urandom));
         ra.tick = !prev_a && ($urandom_range(0, 3) == 0);
         rb.tick = !prev_b && ($urandom_range(0, 3) == 0);
         ra.hit  = ($urandom_range(0, 9) == 0);
         rb.hit  = ($urandom_range(0, 5) == 0);
         ra.rst  = ($urandom_range(0, 299) == 0);
         rb.rst  = ($urandom_range(0, 299) == 0);
         cyc(ra, rb);
         prev_a = ra.tick;
         prev_b = rb.tick;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
